// File: rtl/ad_ip_jesd204_tpl_dac_pkg.sv
// Shared definitions for the JESD204 DAC transport-layer start sequencer.
// State encoding is kept as plain constants so legacy register maps can mirror it.
package ad_ip_jesd204_tpl_dac_pkg;

    localparam int unsigned StateWidth     = 3;
    localparam int unsigned SyncCountWidth = 8;

    localparam logic [StateWidth-1:0] StIdle  = 3'd0;
    localparam logic [StateWidth-1:0] StArmed = 3'd1;
    localparam logic [StateWidth-1:0] StDelay = 3'd2;
    localparam logic [StateWidth-1:0] StSync  = 3'd3;
    localparam logic [StateWidth-1:0] StRun   = 3'd4;

    function automatic logic state_is_armed(input logic [StateWidth-1:0] state);
        return (state == StArmed) || (state == StDelay);
    endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_sync_in.sv
// Two-flop synchronizer followed by a rising-edge detect register.
// Shared between the DAC and ADC transport layers.
module ad_ip_jesd204_tpl_dac_sync_in (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    // [0] and [1] form the synchronizer, [2] is the edge-detect history.
    logic [2:0] sync_d;
    logic [2:0] sync_q;

    always_comb begin
        sync_d = {sync_q[1:0], async_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_start_ctrl.sv
// Start/resync sequencer: arm, wait for a software or external trigger, delay,
// emit a one-cycle data-path sync pulse, then release per-channel DMA valid.
module ad_ip_jesd204_tpl_dac_start_ctrl
    import ad_ip_jesd204_tpl_dac_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS  = 1,
    parameter int unsigned DELAY_WIDTH   = 16,
    parameter int unsigned TIMEOUT_WIDTH = 24
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      link_ready,
    input  logic                      ext_sync,
    input  logic                      ctrl_arm,
    input  logic                      ctrl_abort,
    input  logic                      ctrl_sw_trigger,
    input  logic                      ctrl_ext_sync_en,
    input  logic [DELAY_WIDTH-1:0]    ctrl_delay,
    input  logic [TIMEOUT_WIDTH-1:0]  ctrl_timeout,
    output logic                      dac_sync,
    output logic [NUM_CHANNELS-1:0]   dac_valid,
    output logic                      status_armed,
    output logic                      status_running,
    output logic                      status_timeout,
    output logic [SyncCountWidth-1:0] status_sync_count
);

    logic ext_rise;
    logic trig;
    logic arm_edge;

    logic [StateWidth-1:0]     state_d, state_q;
    logic                      ctrl_arm_d1_d, ctrl_arm_d1_q;
    logic [DELAY_WIDTH-1:0]    delay_lat_d, delay_lat_q;
    logic [TIMEOUT_WIDTH-1:0]  timeout_lat_d, timeout_lat_q;
    logic [DELAY_WIDTH-1:0]    delay_cnt_d, delay_cnt_q;
    logic [TIMEOUT_WIDTH-1:0]  timeout_cnt_d, timeout_cnt_q;
    logic                      dac_sync_d, dac_sync_q;
    logic [NUM_CHANNELS-1:0]   dac_valid_d, dac_valid_q;
    logic                      status_armed_d, status_armed_q;
    logic                      status_running_d, status_running_q;
    logic                      status_timeout_d, status_timeout_q;
    logic [SyncCountWidth-1:0] sync_count_d, sync_count_q;

    ad_ip_jesd204_tpl_dac_sync_in u_sync_in (
        .clk      (clk),
        .reset    (reset),
        .async_in (ext_sync),
        .rise     (ext_rise)
    );

    assign trig     = (ext_rise & ctrl_ext_sync_en) | ctrl_sw_trigger;
    assign arm_edge = ctrl_arm & ~ctrl_arm_d1_q;

    always_comb begin
        state_d          = state_q;
        ctrl_arm_d1_d    = ctrl_arm;
        delay_lat_d      = delay_lat_q;
        timeout_lat_d    = timeout_lat_q;
        delay_cnt_d      = delay_cnt_q;
        timeout_cnt_d    = timeout_cnt_q;
        status_timeout_d = status_timeout_q;
        sync_count_d     = sync_count_q;

        // Abort outranks re-arm, which outranks anything the current state wants.
        if (ctrl_abort) begin
            state_d = StIdle;
        end else if (arm_edge) begin
            state_d          = StArmed;
            delay_lat_d      = ctrl_delay;
            timeout_lat_d    = ctrl_timeout;
            timeout_cnt_d    = '0;
            status_timeout_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                end
                StArmed: begin
                    if (trig) begin
                        state_d     = StDelay;
                        delay_cnt_d = delay_lat_q;
                    end else if ((timeout_lat_q != '0) && (timeout_cnt_q == timeout_lat_q)) begin
                        state_d          = StIdle;
                        status_timeout_d = 1'b1;
                    end else begin
                        timeout_cnt_d = timeout_cnt_q + TIMEOUT_WIDTH'(1);
                    end
                end
                StDelay: begin
                    if (delay_cnt_q == '0) begin
                        state_d = StSync;
                    end else begin
                        delay_cnt_d = delay_cnt_q - DELAY_WIDTH'(1);
                    end
                end
                StSync: begin
                    state_d = StRun;
                end
                StRun: begin
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        // Outputs are registered from the next state so they line up with it.
        dac_sync_d       = (state_d == StSync);
        dac_valid_d      = (state_d == StRun) ? {NUM_CHANNELS{link_ready}} : '0;
        status_armed_d   = state_is_armed(state_d);
        status_running_d = (state_d == StRun);
        if (state_d == StSync) begin
            sync_count_d = sync_count_q + SyncCountWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StIdle;
            ctrl_arm_d1_q    <= 1'b0;
            delay_lat_q      <= '0;
            timeout_lat_q    <= '0;
            delay_cnt_q      <= '0;
            timeout_cnt_q    <= '0;
            dac_sync_q       <= 1'b0;
            dac_valid_q      <= '0;
            status_armed_q   <= 1'b0;
            status_running_q <= 1'b0;
            status_timeout_q <= 1'b0;
            sync_count_q     <= '0;
        end else begin
            state_q          <= state_d;
            ctrl_arm_d1_q    <= ctrl_arm_d1_d;
            delay_lat_q      <= delay_lat_d;
            timeout_lat_q    <= timeout_lat_d;
            delay_cnt_q      <= delay_cnt_d;
            timeout_cnt_q    <= timeout_cnt_d;
            dac_sync_q       <= dac_sync_d;
            dac_valid_q      <= dac_valid_d;
            status_armed_q   <= status_armed_d;
            status_running_q <= status_running_d;
            status_timeout_q <= status_timeout_d;
            sync_count_q     <= sync_count_d;
        end
    end

    assign dac_sync          = dac_sync_q;
    assign dac_valid         = dac_valid_q;
    assign status_armed      = status_armed_q;
    assign status_running    = status_running_q;
    assign status_timeout    = status_timeout_q;
    assign status_sync_count = sync_count_q;

endmodule
